memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 174 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-master RAM arbiter: the data port has priority, bounded by a starvation limit for the instruction port.
// Optional ARB_PERF_CNT_EN adds per-port grant counters (igrant_cnt, dgrant_cnt).
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  output logic [31:0]      iload,
  output logic             iwait,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic [31:0]      dload,
  output logic             dwait,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]      igrant_cnt,
  output logic [31:0]      dgrant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2
  } arb_state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        data_req_s;
  logic        starving_s;
  logic        i_done_s;
  logic        d_done_s;

  assign data_req_s = dREN | dWEN;
  assign starving_s = iREN && (starve_cnt_q == STARVE_MAX);

  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = 1'b1;
    dwait    = 1'b1;
    i_done_s = 1'b0;
    d_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_s && !starving_s) begin
          state_d = DREQ;
        end else if (iREN) begin
          state_d = IREQ;
        end else begin
          state_d = IDLE;
        end
      end
      IREQ: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = (ramstate == ACCESS) ? 1'b0 : 1'b1;
        // A withdrawn request drops the strobe immediately and frees the bus.
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          case (ramstate)
            ACCESS: begin
              state_d  = IDLE;
              i_done_s = 1'b1;
            end
            ERROR:   state_d = IDLE;
            default: state_d = IREQ;
          endcase
        end
      end
      DREQ: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = (ramstate == ACCESS) ? 1'b0 : 1'b1;
        if (!data_req_s) begin
          state_d = IDLE;
        end else begin
          case (ramstate)
            ACCESS: begin
              state_d  = IDLE;
              d_done_s = 1'b1;
            end
            ERROR:   state_d = IDLE;
            default: state_d = DREQ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Consecutive data grants seen while the instruction port waits; saturates at the limit.
  always_comb begin
    if (!iREN) begin
      starve_cnt_d = 4'd0;
    end else if (i_done_s) begin
      starve_cnt_d = 4'd0;
    end else if (d_done_s && (starve_cnt_q < STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] igrant_cnt_q;
  logic [31:0] dgrant_cnt_q;

  // Completed-grant counters, free-running with natural wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      igrant_cnt_q <= 32'd0;
      dgrant_cnt_q <= 32'd0;
    end else begin
      if (i_done_s) begin
        igrant_cnt_q <= igrant_cnt_q + 32'd1;
      end else begin
        igrant_cnt_q <= igrant_cnt_q;
      end
      if (d_done_s) begin
        dgrant_cnt_q <= dgrant_cnt_q + 32'd1;
      end else begin
        dgrant_cnt_q <= dgrant_cnt_q;
      end
    end
  end

  assign igrant_cnt = igrant_cnt_q;
  assign dgrant_cnt = dgrant_cnt_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter plus hand-written starvation, error-retry and reset sequences.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        clk;
  logic        rst;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   rstate;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] igrant_cnt;
  logic [31:0] dgrant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .iREN     (iren),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dren),
    .dWEN     (dwen),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ram_ren),
    .ramWEN   (ram_wen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (rstate)
`ifdef ARB_PERF_CNT_EN
    ,
    .igrant_cnt (igrant_cnt),
    .dgrant_cnt (dgrant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] rl;
    ramstate_t   rs;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iw;
    logic        dw;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [131:0] pack_out();
    return {ram_ren, ram_wen, ramaddr, ramstore, iwait, dwait, iload, dload};
  endfunction

  task automatic drive(input logic i, input logic d, input logic w, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                       input ramstate_t rs);
    iren = i; dren = d; dwen = w; iaddr = ia; daddr = da; dstore = ds; ramload = rl; rstate = rs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  grants [10];
    int          ng;
    logic [7:0]  exp_g;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h11,       32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h11,       32'h0,        BUSY,   1'b1, 1'b0, 32'h100, 32'h11,       1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h11,       32'hCAFE0001, ACCESS, 1'b1, 1'b0, 32'h100, 32'h11,       1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h11,       32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h11,       32'h12345678, ACCESS, 1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h200, 32'hDEADBEEF, 32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h200, 32'hDEADBEEF, 32'h0,        FREE,   1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h200, 32'hDEADBEEF, 32'h0BADF00D, ACCESS, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        32'h0,        BUSY,   1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        32'h77,       ACCESS, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h300, 32'h5,        32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h300, 32'h5,        32'h0,        BUSY,   1'b0, 1'b0, 32'h300, 32'h5,        1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};

    // Reset with requests active: outputs must be quiescent.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 32'h99, 32'h0, ACCESS);
    #12;
    check("reset_outputs", {ram_ren, ram_wen, ramaddr, ramstore, iwait, dwait},
          {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1});
`ifdef ARB_PERF_CNT_EN
    check("reset_counters", {68'h0, igrant_cnt, dgrant_cnt}, 132'h0);
`endif
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    #1 rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].ia, vecs[i].da, vecs[i].ds,
            vecs[i].rl, vecs[i].rs);
      #3;
      check($sformatf("vec%0d", i), pack_out(),
            {vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].store, vecs[i].iw, vecs[i].dw,
             vecs[i].rl, vecs[i].rl});
    end

    // Starvation bound: 4 data grants then 1 instruction grant, repeating.
    ng = 0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h500, 32'h0, 32'h1, ACCESS);
    #3;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      if (!dwait) begin grants[ng] = "D"; ng++; end
      else if (!iwait) begin grants[ng] = "I"; ng++; end
      if (ng < 10) begin @(posedge clk); #4; end
    end
    check("starve_grant_count", 132'(ng), 132'd10);
    for (int k = 0; k < 10; k++) begin
      exp_g = (k % 5 == 4) ? "I" : "D";
      if (k < ng) check($sformatf("starve_grant%0d", k), 132'(grants[k]), 132'(exp_g));
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    @(posedge clk); #1;

    // ERROR during IREQ: retry through IDLE, then complete on ACCESS.
    drive(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, FREE);
    #3 check("err_idle0", {130'h0, ram_ren, iwait}, {130'h0, 1'b0, 1'b1});
    @(posedge clk); #1 rstate = ERROR;
    #3 check("err_ireq", {130'h0, ram_ren, iwait}, {130'h0, 1'b1, 1'b1});
    @(posedge clk); #1 rstate = FREE;
    #3 check("err_retry_idle", {130'h0, ram_ren, iwait}, {130'h0, 1'b0, 1'b1});
    @(posedge clk); #1 rstate = ACCESS; ramload = 32'hA5A5A5A5;
    #3 check("err_complete", {66'h0, ram_ren, iwait, iload, ramaddr},
             {66'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h44});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
`ifdef ARB_PERF_CNT_EN
    #1 check("perf_counts", {68'h0, igrant_cnt, dgrant_cnt}, {68'h0, 32'd4, 32'd10});
`endif

    // Reset asserted mid-DREQ, between clock edges.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h400, 32'h9, 32'h0, BUSY);
    @(posedge clk); #1;
    check("rst_pre_dreq", {98'h0, ram_wen, ramaddr}, {98'h0, 1'b1, 32'h400});
    #1 rst = 1'b1;
    #1 check("rst_async", {66'h0, ram_ren, ram_wen, ramaddr, iwait, dwait},
             {66'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
`ifdef ARB_PERF_CNT_EN
    check("rst_dgrant", {100'h0, dgrant_cnt}, 132'h0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    #1 check("rst_released_idle", {130'h0, ram_wen, dwait}, {130'h0, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
